fetch_pc_unit: RTL and testbench

- Fetch-side consumer of the branch decision. Owns the architectural PC and issues instruction-memory reads over a valid/ready request channel.
- Accepts the registered response and presents the instruction to decode over a valid/ready channel.
- Applies redirects (br_taken/br_target from the branch-condition logic) in any state, squashing wrong-path fetches.

---
 rtl/fetch_pc_unit.sv | 125 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the architectural PC, issues one imem read at a time,
// holds the returned instruction for decode and applies branch redirects.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   br_taken, br_target redirect request and address (target[1:0] ignored)
//   imem_req_*          fetch request channel (valid/ready), addr = pc
//   imem_rsp_*          registered response, single-cycle pulse
//   inst_valid/ready    decode handshake; inst and inst_pc ride with it
//   pc                  current fetch PC register
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] req_pc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        kill;

  logic [31:0] tgt;
  logic        req_fire;
  logic        unused_tgt_lo;

  // Redirect targets are always word aligned.
  assign tgt           = {br_target[31:2], 2'b00};
  assign unused_tgt_lo = ^br_target[1:0];

  assign req_fire = (state == REQ) & imem_req_ready;

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;

  // A redirect in HOLD hides the wrong-path instruction in the same cycle.
  assign inst_valid = (state == HOLD) & ~br_taken;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      req_pc    <= RESET_PC;
      kill      <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (br_taken) pc_q <= tgt;
        end

        REQ: begin
          if (req_fire) begin
            req_pc <= pc_q;
            // A redirect alongside acceptance still lets the request go,
            // but its response must be dropped.
            kill   <= br_taken;
            pc_q   <= br_taken ? tgt : pc_q + 32'd4;
            state  <= WAIT;
          end else if (br_taken) begin
            pc_q <= tgt;
          end
        end

        WAIT: begin
          if (imem_rsp_valid) begin
            if (kill | br_taken) begin
              kill  <= 1'b0;
              state <= REQ;
              if (br_taken) pc_q <= tgt;
            end else begin
              inst_q    <= imem_rsp_data;
              inst_pc_q <= req_pc;
              state     <= HOLD;
            end
          end else if (br_taken) begin
            kill <= 1'b1;
            pc_q <= tgt;
          end
        end

        HOLD: begin
          if (br_taken) begin
            pc_q   <= tgt;
            inst_q <= NOP_INST;
            state  <= REQ;
          end else if (inst_ready) begin
            inst_q <= NOP_INST;
            state  <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed bench for fetch_pc_unit with a small
// imem responder returning 0xAAAA0000 + address after a set delay.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TAG = 32'hAAAA_0000;

  logic        clk;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] pc;

  int n_cmp;
  int n_bad;

  int          mem_delay;
  int          cnt;
  logic [31:0] mem_addr;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .pc             (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: delay 0 means response in the cycle after acceptance.
  always @(posedge clk) begin
    imem_rsp_valid <= 1'b0;
    if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= TAG + mem_addr;
      end
    end else if (imem_req_valid && imem_req_ready) begin
      mem_addr <= imem_req_addr;
      if (mem_delay == 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= TAG + imem_req_addr;
      end else begin
        cnt <= mem_delay;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    nxt();
    nxt();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
    end
    n_cmp++;
    if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_inst: got v=%b i=%h p=%h want 0/%h/0",
               inst_valid, inst, inst_pc, NOP);
    end
    n_cmp++;
    if (pc !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_pc: got %h want 0", pc);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_req_valid: got %b want 0", imem_req_valid);
    end
    nxt();
  endtask

  // Starts in REQ at 0x0; ends in REQ at 0xC.
  task automatic test_stream;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
        n_bad++;
        $display("FAIL stream_req%0d: got v=%b a=%h want 1/%h",
                 k, imem_req_valid, imem_req_addr, 4 * k);
      end
      nxt();
      n_cmp++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stream_wait%0d: got rv=%b iv=%b want 0/0",
                 k, imem_req_valid, inst_valid);
      end
      nxt();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst !== TAG + 32'(4 * k) ||
          inst_pc !== 32'(4 * k)) begin
        n_bad++;
        $display("FAIL stream_inst%0d: got v=%b i=%h p=%h want 1/%h/%h",
                 k, inst_valid, inst, inst_pc, TAG + 32'(4 * k), 4 * k);
      end
      nxt();
    end
  endtask

  // Starts in REQ at 0xC; ends in REQ at 0x10.
  task automatic test_hold_stall;
    inst_ready = 1'b0;
    nxt();
    nxt();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (inst_valid !== 1'b1 || inst !== 32'hAAAA_000C ||
          inst_pc !== 32'hC || imem_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stall%0d: got v=%b i=%h p=%h rv=%b want 1/aaaa000c/c/0",
                 k, inst_valid, inst, inst_pc, imem_req_valid);
      end
      nxt();
    end
    inst_ready = 1'b1;
    nxt();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL stall_release: got v=%b a=%h want 1/10",
               imem_req_valid, imem_req_addr);
    end
  endtask

  // Starts in REQ at 0x10; ends in REQ at 0x100.
  task automatic test_wait_redirect;
    mem_delay = 2;
    nxt();
    br_taken  = 1'b1;
    br_target = 32'h103;
    nxt();
    br_taken  = 1'b0;
    mem_delay = 0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== 32'h100) begin
      n_bad++;
      $display("FAIL wredir_kill: got iv=%b rv=%b pc=%h want 0/0/100",
               inst_valid, imem_req_valid, pc);
    end
    nxt();
    n_cmp++;
    if (imem_rsp_valid !== 1'b1 || inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wredir_rsp: got rsp=%b iv=%b want 1/0",
               imem_rsp_valid, inst_valid);
    end
    nxt();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 ||
        inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wredir_next: got v=%b a=%h iv=%b want 1/100/0",
               imem_req_valid, imem_req_addr, inst_valid);
    end
  endtask

  // Starts in REQ at 0x100; ends in HOLD with 0x200.
  task automatic test_req_redirect;
    imem_req_ready = 1'b0;
    br_taken       = 1'b1;
    br_target      = 32'h200;
    nxt();
    br_taken = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      n_bad++;
      $display("FAIL rredir_addr: got v=%b a=%h want 1/200",
               imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    nxt();
    nxt();
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200 ||
        inst !== 32'hAAAA_0200) begin
      n_bad++;
      $display("FAIL rredir_inst: got v=%b i=%h p=%h want 1/aaaa0200/200",
               inst_valid, inst, inst_pc);
    end
  endtask

  // Starts in HOLD; ends in REQ at 0x40.
  task automatic test_hold_redirect;
    inst_ready = 1'b1;
    br_taken   = 1'b1;
    br_target  = 32'h40;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hredir_mask: got iv=%b want 0", inst_valid);
    end
    nxt();
    br_taken = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40 ||
        inst !== NOP || inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hredir_next: got v=%b a=%h i=%h iv=%b want 1/40/%h/0",
               imem_req_valid, imem_req_addr, inst, inst_valid, NOP);
    end
  endtask

  // Starts in REQ at 0x40.
  task automatic test_wrap_reset;
    imem_req_ready = 1'b0;
    br_taken       = 1'b1;
    br_target      = 32'hFFFF_FFFF;
    nxt();
    br_taken = 1'b0;
    n_cmp++;
    if (imem_req_addr !== 32'hFFFF_FFFC || pc !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL wrap_align: got a=%h pc=%h want fffffffc",
               imem_req_addr, pc);
    end
    imem_req_ready = 1'b1;
    mem_delay      = 2;
    nxt();
    n_cmp++;
    if (pc !== 32'h0 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_pc: got pc=%h rv=%b want 0/0", pc, imem_req_valid);
    end
    br_taken  = 1'b1;
    br_target = 32'h500;
    #1;
    rst = 1'b1;
    #1;
    br_taken = 1'b0;
    n_cmp++;
    if (pc !== 32'h0 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 ||
        inst !== NOP || inst_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL async_rst: got pc=%h rv=%b iv=%b i=%h p=%h",
               pc, imem_req_valid, inst_valid, inst, inst_pc);
    end
    @(negedge clk);
    rst       = 1'b0;
    mem_delay = 0;
    nxt();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 ||
        imem_rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_first_req: got v=%b a=%h rsp=%b want 1/0/1",
               imem_req_valid, imem_req_addr, imem_rsp_valid);
    end
    nxt();
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_stale: got iv=%b rv=%b want 0/0",
               inst_valid, imem_req_valid);
    end
    nxt();
    n_cmp++;
    if (inst_valid !== 1'b1 || inst !== 32'hAAAA_0000 || inst_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_refetch: got v=%b i=%h p=%h want 1/aaaa0000/0",
               inst_valid, inst, inst_pc);
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    cnt            = 0;
    mem_delay      = 0;
    mem_addr       = 32'h0;
    imem_rsp_data  = 32'h0;
    rst            = 1'b1;
    br_taken       = 1'b0;
    br_target      = 32'h0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    test_reset();
    test_stream();
    test_hold_stall();
    test_wait_redirect();
    test_req_redirect();
    test_hold_redirect();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
